gc_scan_ctrl: RTL and testbench

Scan-chain driver for chains of GC scan flip-flops. Takes a parallel test pattern from a host and shifts it serially into a chain's SI, with SE asserted. It then issues one functional capture cycle, shifts the captured response out of the chain's SO, and returns it to the host in parallel. It sits between the test/configuration host logic and the head and tail of a scan chain built from GC_FF cells.

---
 rtl/gc_scan_pkg.sv | 22 ++
 rtl/gc_scan_shreg.sv | 50 +++++
 rtl/gc_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_gc_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_scan_pkg.sv
`default_nettype none
// =============================================================================
// gc_scan_pkg : state encoding and counter sizing shared by the scan driver
// Rev 1.0
// =============================================================================
package gc_scan_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } scan_state_t;

    // Wide enough to hold CHAIN_LEN, so the final increment never wraps.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gc_scan_shreg.sv
`default_nettype none
// =============================================================================
// gc_scan_shreg : parallel-load, serial-in, serial-out right-shift register
// Rev 1.0
// =============================================================================
module gc_scan_shreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] pdata_i,
    input  logic             sin_i,
    output logic             so_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH > 1) begin : g_wide
            assign shifted = {sin_i, sr_q[WIDTH-1:1]};
        end else begin : g_single
            assign shifted = sin_i;
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = pdata_i;
        end else if (shift_i) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign so_o = sr_q[0];

endmodule
`default_nettype wire

// File: rtl/gc_scan_ctrl.sv
`default_nettype none
// =============================================================================
// gc_scan_ctrl : load / capture / unload driver for a GC_FF scan chain
// Optional compare path enabled by GC_SCAN_CTRL_COMPARE_EN.   Rev 1.0
// =============================================================================
module gc_scan_ctrl
    import gc_scan_pkg::*;
#(
    parameter int   CHAIN_LEN = 32,
    parameter logic FILL_BIT  = 1'b0
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
`ifdef GC_SCAN_CTRL_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    output logic                 mismatch,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 scan_se,
    output logic                 scan_en,
    output logic                 scan_si,
    input  logic                 scan_so
);

    localparam int               CNT_W    = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    scan_state_t          state_q;
    scan_state_t          state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [CHAIN_LEN-1:0] resp_q;
    logic [CHAIN_LEN-1:0] resp_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 se_q, se_d;
    logic                 en_q, en_d;
    logic                 accept;
    logic                 load_shift;

    assign accept     = (state_q == IDLE) && start;
    assign load_shift = (state_q == LOAD);

    // Shifting in FILL_BIT during LOAD leaves the register holding FILL_BIT by
    // CAPTURE, so its serial output can drive scan_si directly as a flop.
    gc_scan_shreg #(
        .WIDTH (CHAIN_LEN)
    ) u_pat_sr (
        .clk_i   (C),
        .rst_i   (R),
        .load_i  (accept),
        .shift_i (load_shift),
        .pdata_i (pattern),
        .sin_i   (FILL_BIT),
        .so_o    (scan_si)
    );

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (cnt_q == LAST_IDX) state_d = CAPTURE;
            CAPTURE: state_d = UNLOAD;
            UNLOAD:  if (cnt_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded from the next state so the registered outputs line up with state_q.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        se_d   = 1'b0;
        en_d   = 1'b0;
        case (state_d)
            LOAD: begin
                busy_d = 1'b1;
                se_d   = 1'b1;
                en_d   = 1'b1;
            end
            CAPTURE: begin
                busy_d = 1'b1;
                en_d   = 1'b1;
            end
            UNLOAD: begin
                busy_d = 1'b1;
                se_d   = 1'b1;
                en_d   = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        resp_d = resp_q;
        case (state_q)
            IDLE:         if (start) cnt_d = '0;
            LOAD, UNLOAD: cnt_d = cnt_q + CNT_W'(1);
            CAPTURE:      cnt_d = '0;
            default:      ;
        endcase
        if (state_q == UNLOAD) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                if (cnt_q == CNT_W'(i)) resp_d[i] = scan_so;
            end
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            se_q   <= 1'b0;
            en_q   <= 1'b0;
            cnt_q  <= '0;
            resp_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            se_q   <= se_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            resp_q <= resp_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign scan_se  = se_q;
    assign scan_en  = en_q;
    assign response = resp_q;

`ifdef GC_SCAN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic                 mm_q;
    logic                 mm_d;

    always_comb begin
        mm_d = mm_q;
        if (accept) begin
            mm_d = 1'b0;
        end else if (state_q == UNLOAD) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                if (cnt_q == CNT_W'(i)) mm_d = mm_q | ((scan_so ^ exp_q[i]) & mask_q[i]);
            end
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            exp_q  <= '0;
            mask_q <= '0;
            mm_q   <= 1'b0;
        end else begin
            if (accept) begin
                exp_q  <= expected;
                mask_q <= mask;
            end
            mm_q <= mm_d;
        end
    end

    assign mismatch = mm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gc_scan_ctrl.sv
`default_nettype none
// =============================================================================
// tb_gc_scan_ctrl : gc_scan_ctrl against a 4-cell chain and a 1-cell chain
// Rev 1.0
// =============================================================================
module tb_gc_scan_ctrl;

    localparam int N     = 4;
    localparam int TDONE = 2 * N + 2;

    logic         C       = 1'b0;
    logic         R       = 1'b1;
    logic         start   = 1'b0;
    logic [N-1:0] pattern = '0;
    logic         busy, done, scan_se, scan_en, scan_si, scan_so;
    logic [N-1:0] response;
    logic [N-1:0] chain_q = '0;
    logic [N-1:0] d_tie   = '0;
    logic         cap_en  = 1'b1;
`ifdef GC_SCAN_CTRL_COMPARE_EN
    logic [N-1:0] expected = '0;
    logic [N-1:0] mask     = '0;
    logic         mismatch;
    logic         exp1 = 1'b0;
    logic         mask1 = 1'b0;
    logic         mm1;
`endif

    logic start1   = 1'b0;
    logic pattern1 = 1'b0;
    logic busy1, done1, se1, en1, si1, resp1, so1;
    logic chain1_q = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 C = ~C;

    gc_scan_ctrl #(.CHAIN_LEN(N), .FILL_BIT(1'b0)) u_dut (
        .C        (C),
        .R        (R),
        .start    (start),
        .pattern  (pattern),
`ifdef GC_SCAN_CTRL_COMPARE_EN
        .expected (expected),
        .mask     (mask),
        .mismatch (mismatch),
`endif
        .busy     (busy),
        .done     (done),
        .response (response),
        .scan_se  (scan_se),
        .scan_en  (scan_en),
        .scan_si  (scan_si),
        .scan_so  (scan_so)
    );

    gc_scan_ctrl #(.CHAIN_LEN(1), .FILL_BIT(1'b0)) u_dut1 (
        .C        (C),
        .R        (R),
        .start    (start1),
        .pattern  (pattern1),
`ifdef GC_SCAN_CTRL_COMPARE_EN
        .expected (exp1),
        .mask     (mask1),
        .mismatch (mm1),
`endif
        .busy     (busy1),
        .done     (done1),
        .response (resp1),
        .scan_se  (se1),
        .scan_en  (en1),
        .scan_si  (si1),
        .scan_so  (so1)
    );

    // Chain cell 0 takes SI, SO comes from cell N-1 (held here at bit 0);
    // capture loads D so that an unload returns D in bit order.
    always @(posedge C) begin
        if (scan_en) begin
            if (scan_se)     chain_q <= {scan_si, chain_q[N-1:1]};
            else if (cap_en) chain_q <= d_tie;
        end
    end
    assign scan_so = chain_q[0];

    always @(posedge C) begin
        if (en1) chain1_q <= se1 ? si1 : 1'b0;
    end
    assign so1 = chain1_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: position t within a sequence (0 = idle, 1..TDONE).
    int           t = 0;
    logic [N-1:0] pat_m = '0, d_m = '0, resp_m = '0;
    logic         cap_m = 1'b0;
    bit           m_ld, m_cp, m_ul, m_dn;
`ifdef GC_SCAN_CTRL_COMPARE_EN
    logic [N-1:0] exp_m = '0, mask_m = '0;
    logic         mm_m = 1'b0;
`endif

    initial begin
        forever begin
            @(negedge C);
            if (R) begin
                t      = 0;
                resp_m = '0;
                chk("rst_ctrl", 32'({busy, done, scan_se, scan_en, scan_si}), 32'd0);
                chk("rst_resp", 32'(response), 32'd0);
`ifdef GC_SCAN_CTRL_COMPARE_EN
                mm_m = 1'b0;
                chk("rst_mm", 32'(mismatch), 32'd0);
`endif
            end else begin
                m_ld = (t >= 1) && (t <= N);
                m_cp = (t == N + 1);
                m_ul = (t >= N + 2) && (t <= 2 * N + 1);
                m_dn = (t == TDONE);
                chk("busy", 32'(busy), 32'(m_ld || m_cp || m_ul));
                chk("done", 32'(done), 32'(m_dn));
                chk("scan_se", 32'(scan_se), 32'(m_ld || m_ul));
                chk("scan_en", 32'(scan_en), 32'(m_ld || m_cp || m_ul));
                if (m_ld) chk("scan_si_load", 32'(scan_si), 32'(pat_m[t-1]));
                if (m_cp || m_ul) chk("scan_si_fill", 32'(scan_si), 32'd0);
                if (!m_ul) chk("response", 32'(response), 32'(resp_m));
`ifdef GC_SCAN_CTRL_COMPARE_EN
                if (!m_ul) chk("mismatch", 32'(mismatch), 32'(mm_m));
`endif
                if (m_cp) begin
                    d_m   = d_tie;
                    cap_m = cap_en;
                end
                if (t == 2 * N + 1) begin
                    resp_m = cap_m ? d_m : pat_m;
`ifdef GC_SCAN_CTRL_COMPARE_EN
                    mm_m = |((resp_m ^ exp_m) & mask_m);
`endif
                end
                if (t == 0) begin
                    if (start) begin
                        t     = 1;
                        pat_m = pattern;
`ifdef GC_SCAN_CTRL_COMPARE_EN
                        exp_m  = expected;
                        mask_m = mask;
                        mm_m   = 1'b0;
`endif
                    end
                end else if (t == TDONE) begin
                    t = 0;
                end else begin
                    t++;
                end
            end
        end
    end

    logic [N-1:0] si_exp;
    int           first_done, second_done, ndone;

    task automatic run_one(input logic [N-1:0] pat, input logic cap);
        @(posedge C); #1;
        pattern = pat;
        cap_en  = cap;
        start   = 1'b1;
        @(posedge C); #1;
        start = 1'b0;
        repeat (TDONE) @(negedge C);
    endtask

    initial begin
        repeat (3) @(posedge C);
        #1 R = 1'b0;

        // Single-cell chain: pattern 1 loaded, D = 0 captured.
        start1   = 1'b1;
        pattern1 = 1'b1;
        @(posedge C); #1;
        start1 = 1'b0;
        @(negedge C);
        chk("len1_si_c1", 32'({si1, se1, busy1}), 32'b111);
        @(negedge C);
        chk("len1_cap_c2", 32'({se1, en1}), 32'b01);
        @(negedge C);
        chk("len1_nodone_c3", 32'(done1), 32'd0);
        @(negedge C);
        chk("len1_done_c4", 32'(done1), 32'd1);
        chk("len1_resp", 32'(resp1), 32'd0);
`ifdef GC_SCAN_CTRL_COMPARE_EN
        chk("len1_mm", 32'(mm1), 32'd0);
`endif

        // Basic sequence with literal expectations.
        @(posedge C); #1;
        pattern = 4'b0110;
        d_tie   = 4'b1010;
        cap_en  = 1'b1;
`ifdef GC_SCAN_CTRL_COMPARE_EN
        expected = 4'b1011;
        mask     = 4'b1111;
`endif
        start = 1'b1;
        @(posedge C); #1;
        start  = 1'b0;
        si_exp = 4'b0110;
        for (int k = 1; k <= N; k++) begin
            @(negedge C);
            chk("basic_si", 32'({scan_si, scan_se}), 32'({si_exp[k-1], 1'b1}));
        end
        @(negedge C);
        chk("basic_capture", 32'({scan_se, scan_en}), 32'b01);
        repeat (N) @(negedge C);
        @(negedge C);
        chk("basic_done_c10", 32'(done), 32'd1);
        chk("basic_resp", 32'(response), 32'b1010);
`ifdef GC_SCAN_CTRL_COMPARE_EN
        chk("cmp_mm_full", 32'(mismatch), 32'd1);
        mask = 4'b1110;
        run_one(4'b0110, 1'b1);
        chk("cmp_mm_masked", 32'(mismatch), 32'd0);
`endif

        // Capture disabled: the loaded pattern comes straight back.
        run_one(4'b0110, 1'b0);
        chk("passthru_done", 32'(done), 32'd1);
        chk("passthru_resp", 32'(response), 32'b0110);

        // start held high: only IDLE samples it.
        @(posedge C); #1;
        cap_en      = 1'b1;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        ndone       = 0;
        @(posedge C); #1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge C);
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        chk("held_ndone", 32'(ndone), 32'd2);
        chk("held_first_done", 32'(first_done), 32'd10);
        chk("held_second_done", 32'(second_done), 32'd21);
        @(posedge C); #1;
        start = 1'b0;
        repeat (12) @(posedge C);

        // Asynchronous reset in the middle of LOAD.
        #1;
        pattern = 4'b1111;
        start   = 1'b1;
        @(posedge C); #1;
        start = 1'b0;
        @(posedge C); #2;
        R = 1'b1;
        #1;
        chk("arst_ctrl", 32'({busy, done, scan_se, scan_en, scan_si}), 32'd0);
        chk("arst_resp", 32'(response), 32'd0);
        @(posedge C); #1;
        R     = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge C);
            if (done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);

        // Randomised traffic; the model process checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(posedge C); #1;
            start   = ($urandom_range(0, 3) == 0);
            pattern = N'($urandom);
            d_tie   = N'($urandom);
            cap_en  = 1'($urandom);
`ifdef GC_SCAN_CTRL_COMPARE_EN
            expected = N'($urandom);
            mask     = N'($urandom);
`endif
        end
        @(posedge C); #1;
        start = 1'b0;
        repeat (2 * TDONE) @(negedge C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
